reduction_combiner: RTL and testbench

//  Registered, arbitrated successor to the router's per-node port-merge stage.

---
 rtl/reduction_combiner.sv | 164 ++++++++++++++++
 tb/tb_reduction_combiner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reduction_combiner.sv
// reduction_combiner
//   Merges FAN_IN flit channels onto one registered output channel with
//   valid/ready flow control. Ordinary flits are granted round-robin; flits
//   carrying the reduce flag (bit FLIT_SIZE-1) on ports selected by
//   reduce_mask are held until every masked port presents one. Then all
//   of them are consumed together and a single combined flit is emitted.
//   The combined flit carries the summed payload and the header of the
//   lowest-indexed masked port.
//
//   Optional build macro: REDUCE_SAT_EN
//     defined   : the combined payload saturates at 2^DATA_W-1, and an overflow
//                 sets header bit FLIT_SIZE-2.
//     undefined : the combined payload wraps mod 2^DATA_W, and bit FLIT_SIZE-2
//                 is the header source port's bit.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   in            packed input flits, port i at in[i*FLIT_SIZE +: FLIT_SIZE]
//   in_valid      per-port flit valid
//   in_avail      per-port consume strobe (combinational)
//   reduce_mask   ports contributing to the current reduction
//   out           registered output flit
//   out_valid     output valid
//   out_ready     downstream accept
//   reduce_count  completed reductions (wrapping)
module reduction_combiner #(
  parameter int FAN_IN    = 6,
  parameter int FLIT_SIZE = 82,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_SIZE*FAN_IN-1:0] in,
  input  logic [FAN_IN-1:0]           in_valid,
  output logic [FAN_IN-1:0]           in_avail,
  input  logic [FAN_IN-1:0]           reduce_mask,
  output logic [FLIT_SIZE-1:0]        out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            reduce_count
);

  localparam int PTR_W = (FAN_IN > 1) ? $clog2(FAN_IN) : 1;
`ifdef REDUCE_SAT_EN
  // Enough headroom that the sum of all FAN_IN payloads cannot wrap.
  localparam int SUM_W = DATA_W + PTR_W;

  // Returns {overflow, saturated payload}.
  function automatic logic [DATA_W:0] fit_sum(input logic [SUM_W-1:0] s);
    if (|s[SUM_W-1:DATA_W]) return {1'b1, {DATA_W{1'b1}}};
    return {1'b0, s[DATA_W-1:0]};
  endfunction
`else
  localparam int SUM_W = DATA_W;

  // The accumulator is exactly DATA_W bits wide, so the sum wraps naturally.
  function automatic logic [DATA_W-1:0] fit_sum(input logic [SUM_W-1:0] s);
    return s;
  endfunction
`endif

  logic [FLIT_SIZE-1:0]      flit [FAN_IN];
  logic [FAN_IN-1:0]         r_flag;
  logic [FAN_IN-1:0]         cand;
  logic [FAN_IN-1:0]         grant_oh;
  logic                      load;
  logic                      rdy;
  logic                      any_cand;
  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          grant;
  logic [PTR_W-1:0]          grant_nxt;
  logic [FLIT_SIZE-1:DATA_W] hdr;
  logic [SUM_W-1:0]          sum;
  logic [FLIT_SIZE-1:0]      comb_flit;
  logic [FLIT_SIZE-1:0]      out_p0;
  logic                      vld_p0;
  logic [CNT_W-1:0]          cnt_p0;

  always_comb begin
    for (int i = 0; i < FAN_IN; i++) begin
      flit[i]   = in[i*FLIT_SIZE +: FLIT_SIZE];
      r_flag[i] = flit[i][FLIT_SIZE-1];
    end
  end

  assign load = !vld_p0 || out_ready;
  // Every masked port must present a reduce-flagged flit in this very cycle.
  assign rdy  = (|reduce_mask) && ((reduce_mask & ~(in_valid & r_flag)) == '0);
  assign cand = in_valid & ~(r_flag & reduce_mask);

  // Scanning downward leaves the candidate nearest to rr_ptr as the final winner.
  always_comb begin
    any_cand = 1'b0;
    grant    = '0;
    for (int k = FAN_IN - 1; k >= 0; k--) begin
      if (cand[(int'(rr_ptr) + k) % FAN_IN]) begin
        any_cand = 1'b1;
        grant    = PTR_W'((int'(rr_ptr) + k) % FAN_IN);
      end
    end
  end

  assign grant_nxt = (grant == PTR_W'(FAN_IN - 1)) ? '0 : grant + 1'b1;
  assign grant_oh  = FAN_IN'(1) << grant;

  // Downward scan so the header ends up from the lowest-indexed masked port.
  always_comb begin
    sum = '0;
    hdr = '0;
    for (int i = FAN_IN - 1; i >= 0; i--) begin
      if (reduce_mask[i]) begin
        sum = sum + SUM_W'(flit[i][DATA_W-1:0]);
        hdr = flit[i][FLIT_SIZE-1:DATA_W];
      end
    end
  end

`ifdef REDUCE_SAT_EN
  logic [DATA_W:0] fit;
  always_comb begin
    fit       = fit_sum(sum);
    comb_flit = {hdr, fit[DATA_W-1:0]};
    comb_flit[FLIT_SIZE-2] = hdr[FLIT_SIZE-2] | fit[DATA_W];
  end
`else
  assign comb_flit = {hdr, fit_sum(sum)};
`endif

  always_comb begin
    in_avail = '0;
    if (!rst && load) begin
      if (rdy)           in_avail = reduce_mask;
      else if (any_cand) in_avail = grant_oh;
    end
  end

  // Stage p0: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p0 <= '0;
      vld_p0 <= 1'b0;
      cnt_p0 <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      if (rdy) begin
        out_p0 <= comb_flit;
        vld_p0 <= 1'b1;
        cnt_p0 <= cnt_p0 + 1'b1;
      end else if (any_cand) begin
        out_p0 <= flit[grant];
        vld_p0 <= 1'b1;
        rr_ptr <= grant_nxt;
      end else begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign out          = out_p0;
  assign out_valid    = vld_p0;
  assign reduce_count = cnt_p0;

endmodule

// File: tb/tb_reduction_combiner.sv
module tb_reduction_combiner;

  localparam int FAN_IN    = 6;
  localparam int FLIT_SIZE = 82;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 16;

  typedef logic [FLIT_SIZE-1:0] cv_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [FLIT_SIZE*FAN_IN-1:0] in_bus;
  logic [FAN_IN-1:0]           pv;
  logic [FAN_IN-1:0]           in_avail;
  logic [FAN_IN-1:0]           reduce_mask;
  logic [FLIT_SIZE-1:0]        out;
  logic                        out_valid;
  logic                        out_ready;
  logic [CNT_W-1:0]            reduce_count;

  logic [FLIT_SIZE-1:0] pf [FAN_IN];

  // Reference state: what the output register should hold, as seen by the bench.
  logic                 m_ov;
  logic [FLIT_SIZE-1:0] m_out;
  int                   m_cnt;
  int                   m_rr;

  int n_chk  = 0;
  int n_fail = 0;

  reduction_combiner #(
    .FAN_IN(FAN_IN), .FLIT_SIZE(FLIT_SIZE), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in(in_bus), .in_valid(pv), .in_avail(in_avail),
    .reduce_mask(reduce_mask), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .reduce_count(reduce_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_bus = '0;
    for (int i = 0; i < FAN_IN; i++) in_bus[i*FLIT_SIZE +: FLIT_SIZE] = pf[i];
  end

  task automatic chk(input string tag, input cv_t obs, input cv_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cv_t mk(input logic r, input logic [DATA_W-1:0] p);
    cv_t f;
    f = cv_t'({$urandom(), $urandom(), $urandom()});
    f[FLIT_SIZE-1]    = r;
    f[DATA_W-1:0]     = p;
    return f;
  endfunction

  task automatic model_reset();
    m_ov  = 1'b0;
    m_out = '0;
    m_cnt = 0;
    m_rr  = 0;
  endtask

  // One clock cycle: predict from the rules, check the strobe, clock, check outputs.
  task automatic step(input string tag);
    logic              ld;
    logic              rdy;
    logic [FAN_IN-1:0] ea;
    longint            s;
    int                g;
    int                lo;
    cv_t               nf;
    ld  = !m_ov || out_ready;
    rdy = (reduce_mask != '0);
    for (int i = 0; i < FAN_IN; i++)
      if (reduce_mask[i] && !(pv[i] && pf[i][FLIT_SIZE-1])) rdy = 1'b0;
    ea = '0;
    if (ld) begin
      if (rdy) begin
        s  = 0;
        lo = -1;
        for (int i = 0; i < FAN_IN; i++) begin
          if (reduce_mask[i]) begin
            s += longint'(pf[i][DATA_W-1:0]);
            if (lo < 0) lo = i;
          end
        end
        nf = pf[lo];
`ifdef REDUCE_SAT_EN
        if (s > ((longint'(1) << DATA_W) - 1)) begin
          nf[DATA_W-1:0]  = '1;
          nf[FLIT_SIZE-2] = 1'b1;
        end else begin
          nf[DATA_W-1:0] = DATA_W'(s);
        end
`else
        nf[DATA_W-1:0] = DATA_W'(s);
`endif
        ea    = reduce_mask;
        m_out = nf;
        m_ov  = 1'b1;
        m_cnt++;
      end else begin
        g = -1;
        for (int k = 0; k < FAN_IN; k++) begin
          int i;
          i = (m_rr + k) % FAN_IN;
          if (g < 0 && pv[i] && !(pf[i][FLIT_SIZE-1] && reduce_mask[i])) g = i;
        end
        if (g >= 0) begin
          ea    = FAN_IN'(1) << g;
          m_out = pf[g];
          m_ov  = 1'b1;
          m_rr  = (g + 1) % FAN_IN;
        end else begin
          m_ov = 1'b0;
        end
      end
    end
    #1;
    chk({tag, ":in_avail"}, cv_t'(in_avail), cv_t'(ea));
    @(posedge clk);
    #1;
    pv = pv & ~ea;
    chk({tag, ":out_valid"}, cv_t'(out_valid), cv_t'(m_ov));
    chk({tag, ":out"}, out, m_out);
    chk({tag, ":count"}, cv_t'(reduce_count), cv_t'(CNT_W'(m_cnt)));
  endtask

  initial begin
    cv_t f0, f2, f5;
    rst         = 1'b1;
    pv          = '0;
    reduce_mask = '0;
    out_ready   = 1'b1;
    for (int i = 0; i < FAN_IN; i++) pf[i] = '0;
    model_reset();
    #3;
    chk("reset:out_valid", cv_t'(out_valid), cv_t'(1'b0));
    chk("reset:out", out, '0);
    chk("reset:count", cv_t'(reduce_count), '0);
    chk("reset:in_avail", cv_t'(in_avail), '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin pass-through of ports 0, 2, 5 with no reduction mask.
    f0 = mk(1'b0, $urandom()); f2 = mk(1'b1, $urandom()); f5 = mk(1'b0, $urandom());
    pf[0] = f0; pf[2] = f2; pf[5] = f5; pv = 6'b100101;
    step("rr0"); chk("rr0:flit", out, f0);
    step("rr1"); chk("rr1:flit", out, f2);
    step("rr2"); chk("rr2:flit", out, f5);
    step("rr_idle");

    // Simultaneous three-port reduction of 3+4+5.
    reduce_mask = 6'b000111;
    pf[0] = mk(1'b1, 32'd3); pf[1] = mk(1'b1, 32'd4); pf[2] = mk(1'b1, 32'd5);
    f0 = pf[0];
    pv = 6'b000111;
    step("red3");
    chk("red3:payload", cv_t'(out[DATA_W-1:0]), cv_t'(32'd12));
    chk("red3:header", cv_t'(out[FLIT_SIZE-1:DATA_W]), cv_t'(f0[FLIT_SIZE-1:DATA_W]));
    chk("red3:count", cv_t'(reduce_count), cv_t'(16'd1));
    step("red3_idle");

    // Staggered gather with a pass-through flit slipping in between.
    pf[0] = mk(1'b1, $urandom()); pv[0] = 1'b1;
    step("gat0");
    pf[3] = mk(1'b0, $urandom()); pv[3] = 1'b1;
    step("gat1");
    pf[1] = mk(1'b1, $urandom()); pv[1] = 1'b1;
    step("gat2");
    step("gat3");
    pf[2] = mk(1'b1, $urandom()); pv[2] = 1'b1;
    step("gat4");
    step("gat5");

    // Backpressure: output must hold and nothing may be consumed.
    reduce_mask = '0;
    pf[1] = mk(1'b0, $urandom()); pv[1] = 1'b1;
    step("bp_load");
    f0 = out;
    out_ready = 1'b0;
    pf[4] = mk(1'b0, $urandom()); pv[4] = 1'b1;
    step("bp_hold0"); step("bp_hold1"); step("bp_hold2");
    chk("bp:stable", out, f0);
    out_ready = 1'b1;
    step("bp_release");
    pf[5] = mk(1'b0, $urandom()); pv[5] = 1'b1;
    step("bp_nobubble");
    step("bp_idle");

    // Payload overflow on a two-port reduction.
    reduce_mask = 6'b000011;
    pf[0] = mk(1'b1, 32'hFFFF_FFFF); pf[0][FLIT_SIZE-2] = 1'b0;
    pf[1] = mk(1'b1, 32'd2);
    pv = 6'b000011;
    step("ovf");
`ifdef REDUCE_SAT_EN
    chk("ovf:payload", cv_t'(out[DATA_W-1:0]), cv_t'(32'hFFFF_FFFF));
    chk("ovf:flag", cv_t'(out[FLIT_SIZE-2]), cv_t'(1'b1));
`else
    chk("ovf:payload", cv_t'(out[DATA_W-1:0]), cv_t'(32'd1));
    chk("ovf:flag", cv_t'(out[FLIT_SIZE-2]), cv_t'(1'b0));
`endif
    step("ovf_idle");

    // Reset while port 0 waits for port 1.
    pf[0] = mk(1'b1, $urandom()); pf[3] = mk(1'b0, $urandom());
    pv = 6'b001001;
    step("rst_pre");
    rst = 1'b1;
    #1;
    chk("rst:out_valid", cv_t'(out_valid), cv_t'(1'b0));
    chk("rst:count", cv_t'(reduce_count), '0);
    chk("rst:in_avail", cv_t'(in_avail), '0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst:held", cv_t'(pv[0]), cv_t'(1'b1));
    step("rst_wait");
    pf[1] = mk(1'b1, $urandom()); pv[1] = 1'b1;
    step("rst_complete");
    step("rst_idle");

    // Random traffic against the reference.
    for (int n = 0; n < 400; n++) begin
      if (n % 25 == 0) reduce_mask = FAN_IN'($urandom_range(0, (1 << FAN_IN) - 1));
      for (int i = 0; i < FAN_IN; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pf[i] = mk($urandom_range(0, 2) == 0, $urandom());
          pv[i] = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
